hsv_core_mem_sequencer: RTL and testbench
=========================================

Name: hsv_core_mem_sequencer

Overview:
Sequences decoded memory operations (load, store, fence) from the issue stage onto the core's single data bus port, and returns one completion per operation to commit.
- Stores are posted, with a bounded count of outstanding write responses.
- Loads block until their response, then are aligned and sign/zero-extended.
- Fences drain all outstanding writes before completing.
- Sits between the mem execution stage and the data bus interface.

Parameters:
MAX_PENDING_WRITES, 4, maximum posted stores awaiting bus response (1..15)

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
in_direction  in  1  0 = read (load), 1 = write (store)
in_size  in  2  0 = byte, 1 = half, 2 = word
in_sign_extend  in  1  load result sign-extended when 1
in_fence  in  1  fence operation; address and data ignored
in_address  in  32  byte address (rs1 + imm)
in_wdata  in  32  store data, right-justified
in_tag  in  5  rd address, returned with completion
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_addr  out  32  word-aligned address ({in_address[31:2], 2'b00})
bus_we  out  1  write enable
bus_wstrb  out  4  byte strobes
bus_wdata  out  32  lane-shifted store data
bus_rsp_valid  in  1  response; in order, one per request (read or write)
bus_rsp_rdata  in  32  read data; ignored for writes
out_valid  out  1  completion valid
out_ready  in  1  commit accepts completion
out_data  out  32  load result; 0 for stores and fences
out_tag  out  5  tag of completed op; 0 for fences
out_misaligned  out  1  misaligned-address fault (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, pending-write counter 0, in_ready 0, bus_req_valid 0, out_valid 0, out_data/out_tag/out_misaligned 0.
- FSM states: IDLE, REQ, LOAD_WAIT, DRAIN, DONE.
- IDLE: in_ready = 1. On accept, latch all inputs. Next state:
  - fence -> DRAIN
  - misaligned fault (feature on) -> DONE
  - otherwise -> REQ
- REQ: bus_req_valid = 1; outputs held stable until bus_req_ready.
  - Store: strobes per size and address[1:0]; wdata replicated to lanes (byte x4, half x2). On handshake: counter+1, -> DONE.
  - Load: wstrb = 0. On handshake -> LOAD_WAIT.
  - Stores stay in REQ while counter == MAX_PENDING_WRITES (bus_req_valid = 0 in that case).
- Bus responses:
  - With counter > 0, each bus_rsp_valid retires one write (counter-1), since responses are in order and writes issued earlier.
  - LOAD_WAIT: once counter == 0, the next bus_rsp_valid is the load data. Select byte/half by address[1:0], extend per sign_extend, -> DONE.
  - Counter increment and decrement in the same cycle leave it unchanged.
  - A response with no request outstanding is ignored.
- DRAIN: stays until counter == 0, then -> DONE. A fence with counter already 0 spends 1 cycle in DRAIN.
- DONE: out_valid = 1; out_data/out_tag/out_misaligned stable until out_ready, then -> IDLE. Write responses keep retiring while in DONE.
- Latency, zero bus wait:
  - Store: accept -> out_valid in 2 cycles.
  - Load: 3 cycles + response delay.
- Reset mid-operation: all state and the counter are discarded; in-flight bus responses after reset are ignored.

Optional Feature:
HSV_MEM_MISALIGN_TRAP_EN
- Defined: a half access with address[0] = 1, or a word access with address[1:0] != 0, issues no bus request. The op goes IDLE -> DONE with out_misaligned = 1 and out_data = 0.
- Undefined: out_misaligned is tied to 0. Misaligned offsets are forced aligned (half uses address[1], word uses offset 0) and issued normally.

Test Plan:
- Load byte signed, addr 0x103, rdata 0x80FF_FF_12 -> out_data 0xFFFFFF80, out_tag echoed; load half unsigned, addr 0x102, rdata 0xBEEF1234 -> out_data 0x0000BEEF.
- Store half 0x0000ABCD at 0x202 -> bus_addr 0x200, wstrb 4'b1100, wdata 0xABCDABCD, out_valid 2 cycles after accept.
- Five back-to-back stores with responses withheld, MAX_PENDING_WRITES = 4 -> fifth held in REQ with bus_req_valid 0; one response -> fifth issues.
- Fence after 3 posted stores -> out_valid only after the 3rd bus_rsp_valid; fence with 0 pending -> out_valid 2 cycles after accept.
- Load issued with 2 writes pending -> first 2 responses retire the writes; 3rd response data becomes out_data.
- Word load at 0x301: macro defined -> no bus_req_valid, out_misaligned 1. Macro undefined -> bus_addr 0x300, normal data. Also assert rst_core_n low in LOAD_WAIT -> all outputs 0 immediately, counter 0.

Source files
------------

// File: rtl/hsv_core_mem_sequencer.sv
// hsv_core_mem_sequencer
//   Sequences decoded loads, stores and fences from the issue stage onto the single data bus
//   port and returns exactly one completion per operation to commit.
//   - Stores are posted; up to MAX_PENDING_WRITES write responses may be outstanding.
//   - Loads block until their read response, then are aligned and sign/zero-extended.
//   - Fences complete only once every outstanding write response has returned.
//
// Ports
//   clk_core, rst_core_n            clock, asynchronous active-low reset
//   in_*                            operation offered by the issue stage (valid/ready)
//   bus_req_*, bus_addr/we/wstrb/wdata   bus request channel (valid/ready)
//   bus_rsp_valid, bus_rsp_rdata    in-order bus responses, one per request
//   out_*                           completion to commit (valid/ready)
//
// Build option
//   HSV_MEM_MISALIGN_TRAP_EN  defined: misaligned half/word accesses complete with
//                             out_misaligned = 1 and no bus request. Undefined: offsets are
//                             forced aligned and out_misaligned is tied to 0.
module hsv_core_mem_sequencer #(
  parameter int unsigned MAX_PENDING_WRITES = 4
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_direction,
  input  logic [1:0]  in_size,
  input  logic        in_sign_extend,
  input  logic        in_fence,
  input  logic [31:0] in_address,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_tag,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_tag,
  output logic        out_misaligned
);

  typedef enum logic [2:0] {StIdle, StReq, StLoadWait, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_tag_q, out_tag_d;
  logic        out_mis_q, out_mis_d;

  logic        mis_trap;
  logic [1:0]  off;
  logic        full;
  logic        req_fire;
  logic        retire;
  logic [31:0] rsp_shift;
  logic [31:0] load_val;

`ifdef HSV_MEM_MISALIGN_TRAP_EN
  assign mis_trap = ~in_fence & (((in_size == 2'd1) & in_address[0]) |
                                 (in_size[1] & (in_address[1:0] != 2'b00)));
`else
  assign mis_trap = 1'b0;
`endif

  // Effective lane offset; misaligned halves/words are forced onto their natural boundary.
  always_comb begin
    off = 2'b00;
    if (size_q == 2'd0)      off = addr_q[1:0];
    else if (size_q == 2'd1) off = {addr_q[1], 1'b0};
  end

  assign full          = (cnt_q == 4'(MAX_PENDING_WRITES));
  assign bus_req_valid = (state_q == StReq) & ~(we_q & full);
  assign req_fire      = bus_req_valid & bus_req_ready;
  // Responses are in order, so while writes are outstanding the head response is a write's.
  assign retire        = bus_rsp_valid & (cnt_q != 4'd0);

  assign bus_addr = {addr_q[31:2], 2'b00};
  assign bus_we   = we_q;

  always_comb begin
    bus_wstrb = 4'b0000;
    bus_wdata = wdata_q;
    if (size_q == 2'd0) begin
      bus_wdata = {4{wdata_q[7:0]}};
      if (we_q) bus_wstrb = 4'b0001 << off;
    end else if (size_q == 2'd1) begin
      bus_wdata = {2{wdata_q[15:0]}};
      if (we_q) bus_wstrb = 4'b0011 << off;
    end else begin
      if (we_q) bus_wstrb = 4'b1111;
    end
  end

  assign rsp_shift = bus_rsp_rdata >> {off, 3'b000};

  always_comb begin
    if (size_q == 2'd0)      load_val = {{24{sext_q & rsp_shift[7]}}, rsp_shift[7:0]};
    else if (size_q == 2'd1) load_val = {{16{sext_q & rsp_shift[15]}}, rsp_shift[15:0]};
    else                     load_val = rsp_shift;
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((req_fire & we_q) & ~retire)      cnt_d = cnt_q + 4'd1;
    else if (~(req_fire & we_q) & retire) cnt_d = cnt_q - 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tag_d      = tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    out_mis_d  = out_mis_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          we_d       = in_direction;
          size_d     = in_size;
          sext_d     = in_sign_extend;
          addr_d     = in_address;
          wdata_d    = in_wdata;
          tag_d      = in_tag;
          out_data_d = 32'd0;
          out_tag_d  = in_fence ? 5'd0 : in_tag;
          out_mis_d  = mis_trap;
          if (in_fence)      state_d = StDrain;
          else if (mis_trap) state_d = StDone;
          else               state_d = StReq;
        end
      end
      StReq: begin
        if (req_fire) state_d = we_q ? StDone : StLoadWait;
      end
      StLoadWait: begin
        // Only the response after all earlier writes have retired carries load data.
        if (bus_rsp_valid && cnt_q == 4'd0) begin
          out_data_d = load_val;
          state_d    = StDone;
        end
      end
      StDrain: begin
        if (cnt_q == 4'd0) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      tag_q      <= 5'd0;
      out_data_q <= 32'd0;
      out_tag_q  <= 5'd0;
      out_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      out_mis_q  <= out_mis_d;
    end
  end

  // Gated by reset so the issue stage sees no acceptance while reset is held.
  assign in_ready  = (state_q == StIdle) & rst_core_n;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
`ifdef HSV_MEM_MISALIGN_TRAP_EN
  assign out_misaligned = out_mis_q;
`else
  assign out_misaligned = 1'b0;
`endif

  // tag_q is carried for completeness of the latched operation; out_tag_q is what is returned.
  logic unused_tag;
  assign unused_tag = ^tag_q;

endmodule

// File: tb/tb_hsv_core_mem_sequencer.sv
module tb_hsv_core_mem_sequencer;
  localparam int unsigned MaxPend = 4;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        in_valid, in_ready, in_direction, in_sign_extend, in_fence;
  logic [1:0]  in_size;
  logic [31:0] in_address, in_wdata;
  logic [4:0]  in_tag;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        out_valid, out_ready, out_misaligned;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  hsv_core_mem_sequencer #(.MAX_PENDING_WRITES(MaxPend)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_direction(in_direction),
    .in_size(in_size), .in_sign_extend(in_sign_extend), .in_fence(in_fence),
    .in_address(in_address), .in_wdata(in_wdata), .in_tag(in_tag),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_misaligned(out_misaligned)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte lane selected by the access, arithmetic on whole words.
  function automatic logic [1:0] m_off(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return a[1:0];
    if (sz == 2'd1) return a[1] ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int o = int'(m_off(sz, a));
    if (sz == 2'd0) return 4'(1 << o);
    if (sz == 2'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v = r >> (8 * int'(m_off(sz, a)));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Present one operation at a negedge; it is accepted at the following posedge.
  task automatic present(input logic we, input logic [1:0] sz, input logic sx, input logic fn,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] t);
    in_valid = 1'b1; in_direction = we; in_size = sz; in_sign_extend = sx; in_fence = fn;
    in_address = a; in_wdata = d; in_tag = t;
    @(negedge clk_core);
    in_valid = 1'b0;
  endtask

  task automatic complete();
    out_ready = 1'b1;
    @(negedge clk_core);
    out_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = rd;
    @(negedge clk_core);
    bus_rsp_valid = 1'b0;
  endtask

  task automatic dir_load(input string nm, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] rd, input logic [4:0] t,
                          input logic [31:0] exp);
    present(1'b0, sz, sx, 1'b0, a, 32'd0, t);
    chk({nm, "_req_valid"}, {31'd0, bus_req_valid}, 32'd1);
    chk({nm, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({nm, "_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    bus_req_ready = 1'b1;
    @(negedge clk_core);
    bus_req_ready = 1'b0;
    chk({nm, "_early"}, {31'd0, out_valid}, 32'd0);
    respond(rd);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, {27'd0, out_tag}, {27'd0, t});
    complete();
  endtask

  task automatic wait_out(input string nm, input int bound);
    int n = 0;
    while (!out_valid && n < bound) begin
      @(negedge clk_core);
      n++;
    end
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Random-phase bus model: queue of accepted requests awaiting a response.
  typedef struct packed { logic we; logic [31:0] rdata; } rsp_t;
  rsp_t        rq[$];
  logic        cur_we, cur_sext;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata, exp_ld;

  function automatic int wr_out();
    int w = 0;
    foreach (rq[i]) if (rq[i].we) w++;
    return w;
  endfunction

  task automatic bus_step();
    rsp_t e;
    int   w = wr_out();
    if (bus_req_valid) begin
      chk("rnd_limit", {31'd0, bus_we && (w >= int'(MaxPend))}, 32'd0);
      chk("rnd_addr", bus_addr, {cur_addr[31:2], 2'b00});
      chk("rnd_we", {31'd0, bus_we}, {31'd0, cur_we});
      chk("rnd_wstrb", {28'd0, bus_wstrb}, cur_we ? {28'd0, m_strb(cur_size, cur_addr)} : 32'd0);
      if (cur_we) chk("rnd_wdata", bus_wdata, m_wdata(cur_size, cur_wdata));
    end
    if (rq.size() > 0 && $urandom_range(0, 2) == 0) begin
      e = rq.pop_front();
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = e.rdata;
      if (!e.we) exp_ld = m_load(cur_size, cur_sext, cur_addr, e.rdata);
    end else begin
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = $urandom;
    end
    bus_req_ready = 1'($urandom_range(0, 1));
    if (bus_req_valid && bus_req_ready) begin
      e.we = cur_we;
      e.rdata = $urandom;
      rq.push_back(e);
    end
  endtask

  initial begin
    rst_core_n = 1'b0; in_valid = 1'b0; in_direction = 1'b0; in_size = 2'd0;
    in_sign_extend = 1'b0; in_fence = 1'b0; in_address = 32'd0; in_wdata = 32'd0;
    in_tag = 5'd0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_out_mis", {31'd0, out_misaligned}, 32'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    dir_load("ldb_s", 2'd0, 1'b1, 32'h103, 32'h80FF_FF12, 5'd5, 32'hFFFF_FF80);
    dir_load("ldh_u", 2'd1, 1'b0, 32'h102, 32'hBEEF_1234, 5'd6, 32'h0000_BEEF);

    // Store half: lane shifted, replicated, completion two cycles after accept.
    present(1'b1, 2'd1, 1'b0, 1'b0, 32'h202, 32'h0000_ABCD, 5'd7);
    chk("sth_addr", bus_addr, 32'h200);
    chk("sth_we", {31'd0, bus_we}, 32'd1);
    chk("sth_wstrb", {28'd0, bus_wstrb}, 32'hC);
    chk("sth_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sth_early", {31'd0, out_valid}, 32'd0);
    bus_req_ready = 1'b1;
    @(negedge clk_core);
    bus_req_ready = 1'b0;
    chk("sth_valid", {31'd0, out_valid}, 32'd1);
    chk("sth_data", out_data, 32'd0);
    chk("sth_tag", {27'd0, out_tag}, 32'd7);
    complete();
    respond(32'd0);

    // Five stores with responses withheld: the fifth waits for a free slot.
    bus_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(1'b1, 2'd2, 1'b0, 1'b0, 32'h500 + 32'(4 * i), 32'(i), 5'(10 + i));
      @(negedge clk_core);
      chk("st4_valid", {31'd0, out_valid}, 32'd1);
      complete();
    end
    present(1'b1, 2'd2, 1'b0, 1'b0, 32'h510, 32'h55, 5'd14);
    chk("st5_held", {31'd0, bus_req_valid}, 32'd0);
    @(negedge clk_core);
    chk("st5_held2", {31'd0, bus_req_valid}, 32'd0);
    chk("st5_no_out", {31'd0, out_valid}, 32'd0);
    respond(32'd0);
    chk("st5_issue", {31'd0, bus_req_valid}, 32'd1);
    chk("st5_addr", bus_addr, 32'h510);
    @(negedge clk_core);
    bus_req_ready = 1'b0;
    chk("st5_valid", {31'd0, out_valid}, 32'd1);
    complete();
    respond(32'd0);

    // Fence with three posted stores outstanding.
    present(1'b0, 2'd0, 1'b0, 1'b1, 32'hDEAD, 32'd0, 5'd21);
    for (int k = 0; k < 3; k++) begin
      chk("fence3_early", {31'd0, out_valid}, 32'd0);
      chk("fence3_no_req", {31'd0, bus_req_valid}, 32'd0);
      respond(32'd0);
    end
    wait_out("fence3", 4);
    chk("fence3_tag", {27'd0, out_tag}, 32'd0);
    chk("fence3_data", out_data, 32'd0);
    complete();

    // Fence with nothing outstanding.
    present(1'b0, 2'd0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd22);
    chk("fence0_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk_core);
    chk("fence0_valid", {31'd0, out_valid}, 32'd1);
    complete();

    // Load behind two posted writes: third response is the load data.
    bus_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      present(1'b1, 2'd2, 1'b0, 1'b0, 32'h700, 32'd1, 5'd1);
      @(negedge clk_core);
      complete();
    end
    present(1'b0, 2'd2, 1'b0, 1'b0, 32'h400, 32'd0, 5'd9);
    @(negedge clk_core);
    bus_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("ldp_early", {31'd0, out_valid}, 32'd0);
      respond(32'h1111_1111 * 32'(k + 1));
    end
    chk("ldp_early3", {31'd0, out_valid}, 32'd0);
    respond(32'hCAFE_F00D);
    chk("ldp_valid", {31'd0, out_valid}, 32'd1);
    chk("ldp_data", out_data, 32'hCAFE_F00D);
    chk("ldp_tag", {27'd0, out_tag}, 32'd9);
    complete();

    // Misaligned word load.
`ifdef HSV_MEM_MISALIGN_TRAP_EN
    present(1'b0, 2'd2, 1'b0, 1'b0, 32'h301, 32'd0, 5'd3);
    chk("mis_no_req", {31'd0, bus_req_valid}, 32'd0);
    chk("mis_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_flag", {31'd0, out_misaligned}, 32'd1);
    chk("mis_data", out_data, 32'd0);
    complete();
`else
    dir_load("mis_w", 2'd2, 1'b0, 32'h301, 32'h1357_2468, 5'd3, 32'h1357_2468);
`endif

    // Reset while a load waits with a write still pending.
    bus_req_ready = 1'b1;
    present(1'b1, 2'd2, 1'b0, 1'b0, 32'h800, 32'd7, 5'd2);
    @(negedge clk_core);
    complete();
    present(1'b0, 2'd2, 1'b0, 1'b0, 32'h600, 32'd0, 5'd4);
    @(negedge clk_core);
    bus_req_ready = 1'b0;
    rst_core_n = 1'b0;
    #1;
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mrst_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out_data", out_data, 32'd0);
    chk("mrst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("mrst_bus_addr", bus_addr, 32'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    present(1'b0, 2'd0, 1'b0, 1'b1, 32'd0, 32'd0, 5'd0);
    @(negedge clk_core);
    chk("mrst_cnt_zero", {31'd0, out_valid}, 32'd1);
    complete();
    respond(32'hFFFF_FFFF);
    chk("mrst_stray", {31'd0, out_valid}, 32'd0);
    chk("mrst_stray_rdy", {31'd0, in_ready}, 32'd1);

    // Randomized operations against the reference model and bus queue.
    for (int n = 0; n < 80; n++) begin
      int   kind;
      logic fn;
      logic [4:0] t;
      bit   done = 0;
      bit   seen = 0;
      @(negedge clk_core);
      out_ready = 1'b0;
      bus_step();
      kind = $urandom_range(0, 9);
      fn = (kind >= 8);
      cur_we = (kind >= 4) && !fn;
      cur_size = 2'($urandom_range(0, 2));
      cur_sext = 1'($urandom_range(0, 1));
      cur_addr = $urandom;
      if (cur_size == 2'd1) cur_addr[0] = 1'b0;
      if (cur_size == 2'd2) cur_addr[1:0] = 2'b00;
      cur_wdata = $urandom;
      t = 5'($urandom_range(1, 31));
      chk("rnd_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_direction = cur_we; in_size = cur_size; in_sign_extend = cur_sext;
      in_fence = fn; in_address = cur_addr; in_wdata = cur_wdata; in_tag = t;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk_core);
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (out_valid && !seen) begin
          seen = 1;
          if (fn) chk("rnd_fence_drain", 32'(wr_out()), 32'd0);
          chk("rnd_tag", {27'd0, out_tag}, fn ? 32'd0 : {27'd0, t});
          chk("rnd_data", out_data, (fn || cur_we) ? 32'd0 : exp_ld);
          chk("rnd_mis", {31'd0, out_misaligned}, 32'd0);
        end
        bus_step();
        if (out_valid && $urandom_range(0, 1) == 1) begin
          out_ready = 1'b1;
          done = 1;
          break;
        end
      end
      if (!done) chk("rnd_timeout", 32'd0, 32'd1);
    end
    @(negedge clk_core);
    out_ready = 1'b0;
    bus_rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
